fpu_seq: RTL

FPU_SEQ -- requirements
Module: fpu_seq

---
 rtl/fpu_seq.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/fpu_seq.sv
// fpu_seq: sequences one FP instruction through an external FPU (issue, wait, writeback) and owns frm/fflags.
// Optional FPU_SEQ_TIMEOUT_EN adds a 64-cycle WAIT watchdog that aborts the operation and raises NV.
module fpu_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [6:0]  req_funct7,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic [4:0]  req_rd,
  input  logic [2:0]  req_rm,
  output logic [4:0]  rf_rs1,
  output logic [4:0]  rf_rs2,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  output logic        fpu_start,
  output logic [31:0] fpu_op1,
  output logic [31:0] fpu_op2,
  output logic [6:0]  fpu_funct7,
  output logic [2:0]  fpu_frm,
  input  logic        fpu_done,
  input  logic [31:0] fpu_result,
  input  logic [4:0]  fpu_flags,
  output logic        rf_wen,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wdata,
  output logic        illegal,
  output logic        busy,
  input  logic        csr_we,
  input  logic [7:0]  csr_wdata,
  output logic [2:0]  csr_frm,
  output logic [4:0]  csr_fflags
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_WB    = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [6:0]  funct7_q;
  logic [4:0]  rs1_q, rs2_q, rd_q;
  logic [2:0]  frm_q;
  logic [31:0] op1_q, op2_q, result_q;
  logic [4:0]  flags_q;
  logic        illegal_q, illegal_d;
  logic [2:0]  csr_frm_q, csr_frm_d;
  logic [4:0]  csr_fflags_q, csr_fflags_d;
  logic        accept, rm_bad, timeout;
  logic [2:0]  rm_res;

  assign accept = req_valid && (state_q == S_IDLE);
  assign rm_res = (req_rm == 3'b111) ? csr_frm_q : req_rm;
  assign rm_bad = (rm_res >= 3'b101);

`ifdef FPU_SEQ_TIMEOUT_EN
  logic [5:0] wait_cnt_q, wait_cnt_d;

  // Held at zero outside WAIT, so it always starts from zero on entry.
  assign wait_cnt_d = (state_q == S_WAIT) ? wait_cnt_q + 6'd1 : 6'd0;
  assign timeout    = (state_q == S_WAIT) && !fpu_done && (wait_cnt_q == 6'd63);

  always_ff @(posedge clk) begin
    if (rst) wait_cnt_q <= 6'd0;
    else     wait_cnt_q <= wait_cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_ISSUE;
      S_ISSUE: state_d = illegal_q ? S_IDLE : S_WAIT;
      S_WAIT: begin
        if (fpu_done)     state_d = S_WB;
        else if (timeout) state_d = S_IDLE;
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // An illegal request still visits ISSUE for one cycle; illegal_q marks it so no start is issued.
  assign illegal_d = (accept && rm_bad) || timeout;

  always_comb begin
    csr_frm_d    = csr_frm_q;
    csr_fflags_d = csr_fflags_q;
    if (csr_we)                 {csr_frm_d, csr_fflags_d} = csr_wdata;
    else if (state_q == S_WB)   csr_fflags_d = csr_fflags_q | flags_q;
    else if (timeout)           csr_fflags_d = csr_fflags_q | 5'b10000;
  end

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      illegal_q    <= 1'b0;
      csr_frm_q    <= 3'd0;
      csr_fflags_q <= 5'd0;
      funct7_q     <= 7'd0;
      rs1_q        <= 5'd0;
      rs2_q        <= 5'd0;
      rd_q         <= 5'd0;
      frm_q        <= 3'd0;
      op1_q        <= 32'd0;
      op2_q        <= 32'd0;
      result_q     <= 32'd0;
      flags_q      <= 5'd0;
    end else begin
      state_q      <= state_d;
      illegal_q    <= illegal_d;
      csr_frm_q    <= csr_frm_d;
      csr_fflags_q <= csr_fflags_d;
      if (accept) begin
        funct7_q <= req_funct7;
        rs1_q    <= req_rs1;
        rs2_q    <= req_rs2;
        rd_q     <= req_rd;
        frm_q    <= rm_res;
      end
      if ((state_q == S_ISSUE) && !illegal_q) begin
        op1_q <= rf_rdata1;
        op2_q <= rf_rdata2;
      end
      if ((state_q == S_WAIT) && fpu_done) begin
        result_q <= fpu_result;
        flags_q  <= fpu_flags;
      end
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign fpu_start  = (state_q == S_ISSUE) && !illegal_q;
  assign rf_wen     = (state_q == S_WB);
  assign illegal    = illegal_q;
  assign rf_rs1     = rs1_q;
  assign rf_rs2     = rs2_q;
  assign fpu_op1    = op1_q;
  assign fpu_op2    = op2_q;
  assign fpu_funct7 = funct7_q;
  assign fpu_frm    = frm_q;
  assign rf_rd      = rd_q;
  assign rf_wdata   = result_q;
  assign csr_frm    = csr_frm_q;
  assign csr_fflags = csr_fflags_q;

endmodule
